vmem_beat_adapter: RTL and testbench
====================================

VMEM_BEAT_ADAPTER -- requirements
Module: vmem_beat_adapter

Interface
REQ-001 SHALL have parameter VLEN, default 256, meaning vector request width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, meaning memory beat width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte and beat address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1: request handshake.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  request byte address.
REQ-009 SHALL have ports req_wdata and req_wmask, both input VLEN: write data and per-bit write mask.
REQ-010 SHALL have ports resp_valid output 1, resp_ready input 1: response handshake.
REQ-011 SHALL have port resp_rdata  output  VLEN  assembled read data.
REQ-012 SHALL have port resp_err  output  1  request was misaligned.
REQ-013 SHALL have ports mem_ren output 1, mem_raddr output ADDR_W, mem_rdata input BEAT_W: beat read port with 1-cycle registered latency.
REQ-014 SHALL have ports mem_wen output 1, mem_waddr output ADDR_W, mem_wdata output BEAT_W, mem_wmask output BEAT_W: beat write port.

Function
REQ-015 SHALL define N = VLEN/BEAT_W and B = BEAT_W/8; elaboration SHALL fail unless N >= 2, N is a power of two, and BEAT_W >= 8 is a power of two.
REQ-016 SHALL assert req_ready only in state IDLE; acceptance occurs on a rising edge with req_valid && req_ready (cycle 0).
REQ-017 SHALL use states IDLE, RD, WR and RESP.
REQ-018 SHALL compute beat k address as (req_addr >> log2(B)) + k, with k = 0..N-1, wrapping modulo 2^ADDR_W.
REQ-019 SHALL treat a request as misaligned when req_addr mod (VLEN/8) != 0; on acceptance it SHALL issue no memory strobes, go to RESP, and set resp_err=1 with resp_rdata=0 in cycle 1.
REQ-020 SHALL handle an aligned read in RD: mem_ren=1 in cycles 1..N with beat c-1; mem_rdata in cycle c+1 captured into slice [(c-1)*BEAT_W +: BEAT_W]; resp_valid first high in cycle N+2.
REQ-021 SHALL handle an aligned write in WR: for each beat k in ascending order whose mask slice is nonzero, mem_wen=1 for one cycle with that slice's data and mask, back-to-back from cycle 1; beats with an all-zero mask slice SHALL be skipped with no cycle consumed.
REQ-022 SHALL assert resp_valid, with resp_err=0, the cycle after the last write, or in cycle 1 if every mask slice is zero.
REQ-023 SHALL hold resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready, then return to IDLE; the next request can be accepted in the cycle after the response handshake.
REQ-024 SHALL keep mem_ren, mem_wen and mem_wmask at 0 outside active beats; mem addresses and mem_wdata are don't-care when their strobe is 0.
REQ-025 SHALL register the request (we, address, wdata, wmask) at acceptance so that upstream changes after acceptance have no effect.
REQ-026 SHALL never assert mem_ren and mem_wen in the same cycle.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, all counters to 0, and req_ready, resp_valid, resp_err, resp_rdata, mem_ren and mem_wen to 0, asynchronously.
REQ-028 SHALL, on reset mid-operation, abandon the transfer with no further memory strobes and no response; req_ready=1 from the first clock edge after rst is released.

Structure
REQ-029 SHALL place the state encoding and derived constants (N, B, beat-index width clog2(N)) in the shared vector-memory package.
REQ-030 SHALL be a single module with no sub-module; beat selection uses a clog2(N)-bit counter plus a priority search over the nonzero-mask slices.

Verification
Cases use defaults (N=4, B=8); cycle numbers are counted from acceptance.
REQ-031 SHALL cover: read at 0x100 -> mem_raddr 0x20,0x21,0x22,0x23 in cycles 1-4; resp_valid in cycle 6; resp_rdata = {d3,d2,d1,d0}.
REQ-032 SHALL cover: write at 0x40 with a full mask -> mem_waddr 0x08..0x0B in cycles 1-4; resp_valid in cycle 5.
REQ-033 SHALL cover: write at 0x40 with only mask bits [191:128] set -> a single mem_wen at waddr 0x0A in cycle 1; resp_valid in cycle 2.
REQ-034 SHALL cover: misaligned request at 0x104 -> no mem strobes; resp_valid=1 and resp_err=1 in cycle 1.
REQ-035 SHALL cover: resp_ready held at 0 for 3 cycles -> response held stable and req_ready=0 throughout; a new request is accepted the cycle after the handshake.
REQ-036 SHALL cover: rst driven to 0 in cycle 2 of a read -> all outputs 0 immediately; no mem_ren after release; no resp_valid.

Source files
------------

// File: rtl/vmem_beat_adapter_pkg.sv
// Shared vector-memory definitions: adapter FSM encoding and helpers that
// derive beat count, beat size and beat-index width from the widths.
package vmem_beat_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } vmem_state_e;

    function automatic int beat_count(input int vlen, input int beat_w);
        return vlen / beat_w;
    endfunction

    function automatic int beat_bytes(input int beat_w);
        return beat_w / 8;
    endfunction

    function automatic int beat_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vmem_beat_adapter.sv
// Splits one VLEN-wide vector load/store into BEAT_W-wide memory beats and
// returns a single response; misaligned requests are rejected with resp_err.
module vmem_beat_adapter
    import vmem_beat_adapter_pkg::*;
#(
    parameter int VLEN   = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [VLEN-1:0]   req_wdata,
    input  logic [VLEN-1:0]   req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [VLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [BEAT_W-1:0] mem_wdata,
    output logic [BEAT_W-1:0] mem_wmask,
    output vmem_state_e       dbg_state
);

    localparam int N        = beat_count(VLEN, BEAT_W);
    localparam int B        = beat_bytes(BEAT_W);
    localparam int IW       = beat_idx_w(N);
    localparam int BEAT_SH  = $clog2(B);
    localparam int ALIGN_SH = $clog2(VLEN / 8);

    generate
        if (N < 2 || !is_pow2(N) || BEAT_W < 8 || !is_pow2(BEAT_W) || N * BEAT_W != VLEN)
        begin : g_bad_cfg
            $error("vmem_beat_adapter: unsupported VLEN/BEAT_W combination");
        end
    endgenerate

    vmem_state_e       state, state_next;
    logic [IW-1:0]     cnt, cnt_next, sel, cap_idx;
    logic              cap_valid, ready_en, more, accept, misaligned;
    logic [ADDR_W-1:0] base_q;
    logic [VLEN-1:0]   wdata_q, wmask_q, rdata_q;
    logic              err_q;
    logic [N-1:0]      nz;

    assign accept     = req_valid && req_ready;
    assign misaligned = (req_addr[ALIGN_SH-1:0] != '0);
    // Read data lags its strobe by one cycle, so the beat landing now is cnt-1.
    assign cap_idx    = cnt - 1'b1;

    // Lowest nonzero-mask beat at or above cnt, and whether any follow it.
    always_comb begin
        nz   = '0;
        sel  = '0;
        more = 1'b0;
        for (int k = 0; k < N; k++) nz[k] = |wmask_q[k*BEAT_W +: BEAT_W];
        for (int k = N - 1; k >= 0; k--) begin
            if (nz[k] && IW'(k) >= cnt) sel = IW'(k);
        end
        for (int k = 0; k < N; k++) begin
            if (nz[k] && IW'(k) > sel) more = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (accept) begin
                    if (misaligned)      state_next = RESP;
                    else if (!req_we)    state_next = RD;
                    else if (|req_wmask) state_next = WR;
                    else                 state_next = RESP;
                end
            end
            RD: begin
                // cnt wraps to 0 after the last strobe; that cycle only captures.
                mem_ren = !(cap_valid && cnt == '0);
                if (mem_ren) cnt_next = cnt + 1'b1;
                else         state_next = RESP;
            end
            WR: begin
                mem_wen = 1'b1;
                if (more) begin
                    cnt_next = sel + 1'b1;
                end else begin
                    cnt_next   = '0;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en  <= 1'b0;
            cap_valid <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            cap_valid <= mem_ren;
            if (accept) begin
                base_q  <= req_addr >> BEAT_SH;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
                rdata_q <= '0;
                err_q   <= misaligned;
            end else if (state == RD && cap_valid) begin
                rdata_q[int'(cap_idx)*BEAT_W +: BEAT_W] <= mem_rdata;
            end
        end
    end

    assign req_ready  = (state == IDLE) && ready_en;
    assign resp_valid = (state == RESP);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign mem_raddr  = base_q + ADDR_W'(cnt);
    assign mem_waddr  = base_q + ADDR_W'(sel);
    assign mem_wdata  = wdata_q[int'(sel)*BEAT_W +: BEAT_W];
    assign mem_wmask  = mem_wen ? wmask_q[int'(sel)*BEAT_W +: BEAT_W] : '0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_vmem_beat_adapter.sv
// Randomized bench for vmem_beat_adapter: a behavioural beat memory plus a
// spec-level reference model of strobe timing, addresses and read data.
module tb_vmem_beat_adapter;
    import vmem_beat_adapter_pkg::*;

    localparam int VLEN   = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int N      = VLEN / BEAT_W;
    localparam int B      = BEAT_W / 8;
    localparam int MEM_D  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0, req_we = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [VLEN-1:0]   req_wdata = '0, req_wmask = '0;
    logic              resp_valid, resp_err;
    logic              resp_ready = 1'b0;
    logic [VLEN-1:0]   resp_rdata;
    logic              mem_ren, mem_wen;
    logic [ADDR_W-1:0] mem_raddr, mem_waddr;
    logic [BEAT_W-1:0] mem_rdata = '0;
    logic [BEAT_W-1:0] mem_wdata, mem_wmask;
    vmem_state_e       dbg_state;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    vmem_beat_adapter #(.VLEN(VLEN), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .dbg_state(dbg_state)
    );

    function automatic logic [BEAT_W-1:0] init_word(input int i);
        return {8'hC0, 24'(i), 32'h9E3779B9 * 32'(i + 1)};
    endfunction

    // Beat memory seen by the DUT: one-cycle registered read, masked write.
    logic [BEAT_W-1:0] mem [MEM_D];
    logic              mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MEM_D; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_ren) mem_rdata <= mem[mem_raddr[5:0]];
            if (mem_wen)
                mem[mem_waddr[5:0]] <= (mem[mem_waddr[5:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    // Reference model state and expected strobe queues.
    logic [BEAT_W-1:0] ref_mem [MEM_D];
    logic [ADDR_W-1:0] exp_raddr_q[$], exp_waddr_q[$];
    logic [31:0]       exp_rcyc_q[$], exp_wcyc_q[$];
    logic [BEAT_W-1:0] exp_wdata_q[$], exp_wmask_q[$];

    task automatic check_val(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [VLEN-1:0] rand_mask();
        logic [VLEN-1:0] m;
        m = rand_vec();
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 2))
                0:       m[k*BEAT_W +: BEAT_W] = '0;
                1:       m[k*BEAT_W +: BEAT_W] = '1;
                default: ;
            endcase
        end
        return m;
    endfunction

    // Present one request, follow it to its response, then hold resp_ready low
    // for 'hold' cycles before completing the handshake.
    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [VLEN-1:0] wdata, input logic [VLEN-1:0] wmask,
                           input int hold);
        logic              mis, done;
        logic [ADDR_W-1:0] base;
        logic [VLEN-1:0]   exp_rdata, seen_rdata;
        logic              seen_err;
        logic [BEAT_W-1:0] m, d;
        int                exp_resp_cyc, nw, wait_n, rel;
        int                idx;

        mis = (addr % (VLEN / 8)) != 0;
        base = addr / B;
        exp_rdata = '0;
        nw = 0;
        if (mis) begin
            exp_resp_cyc = 1;
        end else if (!we) begin
            for (int k = 0; k < N; k++) begin
                exp_raddr_q.push_back(base + ADDR_W'(k));
                exp_rcyc_q.push_back(32'(k + 1));
                idx = int'((base + ADDR_W'(k)) % MEM_D);
                exp_rdata[k*BEAT_W +: BEAT_W] = ref_mem[idx];
            end
            exp_resp_cyc = N + 2;
        end else begin
            for (int k = 0; k < N; k++) begin
                m = wmask[k*BEAT_W +: BEAT_W];
                d = wdata[k*BEAT_W +: BEAT_W];
                if (m != '0) begin
                    nw++;
                    exp_waddr_q.push_back(base + ADDR_W'(k));
                    exp_wcyc_q.push_back(32'(nw));
                    exp_wdata_q.push_back(d);
                    exp_wmask_q.push_back(m);
                    idx = int'((base + ADDR_W'(k)) % MEM_D);
                    ref_mem[idx] = (ref_mem[idx] & ~m) | (d & m);
                end
            end
            exp_resp_cyc = nw + 1;
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check_val("accept_wait", wait_n, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
        req_wdata = rand_vec(); req_wmask = rand_vec();

        done = 1'b0;
        rel = 0;
        seen_rdata = '0;
        seen_err = 1'b0;
        while (!done && rel < 40) begin
            @(negedge clk);
            rel++;
            check_val("ren_wen_excl", mem_ren & mem_wen, 0);
            check_val("busy_ready", req_ready, 0);
            if (!mem_wen) check_val("idle_wmask", mem_wmask, 0);
            if (mem_ren) begin
                if (exp_raddr_q.size() == 0) check_val("rd_extra", 1, 0);
                else begin
                    check_val("rd_addr", mem_raddr, exp_raddr_q.pop_front());
                    check_val("rd_cycle", rel, exp_rcyc_q.pop_front());
                end
            end
            if (mem_wen) begin
                if (exp_waddr_q.size() == 0) check_val("wr_extra", 1, 0);
                else begin
                    check_val("wr_addr", mem_waddr, exp_waddr_q.pop_front());
                    check_val("wr_cycle", rel, exp_wcyc_q.pop_front());
                    check_val("wr_data", mem_wdata, exp_wdata_q.pop_front());
                    check_val("wr_mask", mem_wmask, exp_wmask_q.pop_front());
                end
            end
            if (resp_valid) begin
                done = 1'b1;
                check_val("resp_cycle", rel, exp_resp_cyc);
                check_val("resp_err", resp_err, mis);
                if (mis || !we) check_val("resp_rdata", resp_rdata, exp_rdata);
                seen_rdata = resp_rdata;
                seen_err = resp_err;
            end
        end
        if (!done) begin
            check_val("resp_timeout", 0, 1);
        end else begin
            check_val("rd_missing", exp_raddr_q.size(), 0);
            check_val("wr_missing", exp_waddr_q.size(), 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_val("hold_valid", resp_valid, 1);
                check_val("hold_rdata", resp_rdata, seen_rdata);
                check_val("hold_err", resp_err, seen_err);
                check_val("hold_ready", req_ready, 0);
                check_val("hold_strobes", mem_ren | mem_wen, 0);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            check_val("post_hs_ready", req_ready, 1);
            check_val("post_hs_valid", resp_valid, 0);
        end
        exp_raddr_q.delete(); exp_rcyc_q.delete();
        exp_waddr_q.delete(); exp_wcyc_q.delete();
        exp_wdata_q.delete(); exp_wmask_q.delete();
    endtask

    // Reset asserted in cycle 2 of a read: outputs clear at once, nothing follows.
    task automatic reset_mid_read(input logic [ADDR_W-1:0] addr);
        int wait_n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check_val("rst_accept_wait", wait_n, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("rst_pre_ren", mem_ren, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_resp_err", resp_err, 0);
        check_val("rst_resp_rdata", resp_rdata, 0);
        check_val("rst_mem_ren", mem_ren, 0);
        check_val("rst_mem_wen", mem_wen, 0);
        repeat (2) @(negedge clk);
        check_val("rst_hold_ren", mem_ren, 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("post_rst_ren", mem_ren, 0);
            check_val("post_rst_wen", mem_wen, 0);
            check_val("post_rst_resp", resp_valid, 0);
            check_val("post_rst_ready", req_ready, 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [VLEN-1:0]   mask;

        for (int i = 0; i < MEM_D; i++) ref_mem[i] = init_word(i);

        repeat (3) @(negedge clk);
        check_val("reset_req_ready", req_ready, 0);
        check_val("reset_resp_valid", resp_valid, 0);
        check_val("reset_resp_err", resp_err, 0);
        check_val("reset_resp_rdata", resp_rdata, 0);
        check_val("reset_mem_ren", mem_ren, 0);
        check_val("reset_mem_wen", mem_wen, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("first_ready", req_ready, 1);

        run_txn(1'b0, 32'h100, '0, '0, 0);
        run_txn(1'b1, 32'h40, rand_vec(), '1, 0);
        mask = '0;
        mask[191:128] = '1;
        run_txn(1'b1, 32'h40, rand_vec(), mask, 0);
        run_txn(1'b0, 32'h104, '0, '0, 0);
        run_txn(1'b1, 32'h104, rand_vec(), '1, 0);
        run_txn(1'b1, 32'h60, rand_vec(), '0, 1);
        run_txn(1'b0, 32'h40, '0, '0, 3);
        run_txn(1'b0, 32'h60, '0, '0, 0);

        reset_mid_read(32'h100);
        run_txn(1'b0, 32'h100, '0, '0, 0);

        for (int t = 0; t < 60; t++) begin
            we = 1'(($urandom_range(0, 1)));
            addr = 32'(32 * $urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 31));
            run_txn(we, addr, rand_vec(), rand_mask(), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
